// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: owner IDs and grant-state encodings shared by the arbiter slice
package sram_like_arbiter_pkg;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  typedef enum logic [1:0] {GNT_IDLE, GNT_INST, GNT_DATA} gnt_state_t;
endpackage

// File: rtl/sram_like_arbiter_owner_id_fifo.sv
// owner_id_fifo: in-order 1-bit owner tags for requests accepted but not yet answered
module owner_id_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] ids;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = ids[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= din;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave port between inst fetch and load/store masters
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        protocol_err
);
  gnt_state_t state, state_nxt;
  logic sel_inst, sel_data, full, empty, head, push, pop;
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= GNT_IDLE;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_data_ok && count == '0) protocol_err <= 1'b1;
    end
  end
  // A stalled request keeps its master granted so the slave sees a stable channel.
  always_comb begin
    sel_data = state == GNT_DATA || (state == GNT_IDLE && data_sram_req);
    sel_inst = state == GNT_INST || (state == GNT_IDLE && !data_sram_req && inst_sram_req);
    mem_req = ((sel_data && data_sram_req) || (sel_inst && inst_sram_req)) && !full;
    push = mem_req && mem_addr_ok;
    pop = mem_data_ok && !empty;
    state_nxt = mem_req && !mem_addr_ok ? (sel_data ? GNT_DATA : GNT_INST) : GNT_IDLE;
  end
  assign mem_wr = sel_data ? data_sram_wr : sel_inst ? inst_sram_wr : 1'b0;
  assign mem_size = sel_data ? data_sram_size : sel_inst ? inst_sram_size : 2'd0;
  assign mem_wstrb = sel_data ? data_sram_wstrb : sel_inst ? inst_sram_wstrb : 4'd0;
  assign mem_addr = sel_data ? data_sram_addr : sel_inst ? inst_sram_addr : 32'd0;
  assign mem_wdata = sel_data ? data_sram_wdata : sel_inst ? inst_sram_wdata : 32'd0;
  assign inst_sram_addr_ok = push && sel_inst;
  assign data_sram_addr_ok = push && sel_data;
  assign inst_sram_data_ok = pop && head == ID_INST;
  assign data_sram_data_ok = pop && head == ID_DATA;
  assign inst_sram_rdata = mem_rdata;
  assign data_sram_rdata = mem_rdata;
  owner_id_fifo #(.DEPTH(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_ids (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(sel_data ? ID_DATA : ID_INST),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: randomized masters and slave with a queue-based scoreboard
module tb_sram_like_arbiter;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic inst_sram_req = 0, inst_sram_wr = 0, data_sram_req = 0, data_sram_wr = 0;
  logic [1:0] inst_sram_size = 0, data_sram_size = 0, mem_size;
  logic [3:0] inst_sram_wstrb = 0, data_sram_wstrb = 0, mem_wstrb;
  logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0, data_sram_addr = 0, data_sram_wdata = 0;
  logic [31:0] inst_sram_rdata, data_sram_rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok;
  logic mem_req, mem_wr, mem_addr_ok = 0, mem_data_ok = 0, protocol_err;

  sram_like_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .protocol_err(protocol_err)
  );

  typedef struct {logic [31:0] addr; int due;} sreq_t;
  sreq_t slave_q[$];
  logic [31:0] exp_inst[$], exp_data[$];
  int checks = 0, passes = 0, cyc = 0;
  int inst_left = 0, data_left = 0, inst_n = 0, data_n = 0;
  int issue_pct = 100, ok_pct = 100, lat_min = 1, lat_max = 1, held_owner = 0;
  logic held = 0, inst_acc = 0, data_acc = 0, force_stall = 0, force_dok = 0, spur = 0, perr_exp = 0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'h83dd_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: fixed data-over-inst priority, a stalled grant is held, at most 4 outstanding.
  task automatic eval();
    int g;
    logic [31:0] ga;
    logic req_exp, acc;
    inst_acc = 0;
    data_acc = 0;
    g = held ? held_owner : data_sram_req ? 1 : inst_sram_req ? 0 : -1;
    ga = g == 1 ? data_sram_addr : inst_sram_addr;
    req_exp = (g == 1 ? data_sram_req : g == 0 ? inst_sram_req : 1'b0) && slave_q.size() < 4;
    chk("mem_req", mem_req, req_exp);
    if (req_exp) begin
      chk("mem_addr", mem_addr, ga);
      if (g == 1) chk("mem_wdata", mem_wdata, data_sram_wdata);
    end
    acc = req_exp && mem_addr_ok;
    chk("inst_addr_ok", inst_sram_addr_ok, acc && g == 0);
    chk("data_addr_ok", data_sram_addr_ok, acc && g == 1);
    chk("protocol_err", protocol_err, perr_exp);
    if (mem_data_ok) begin
      if (spur) perr_exp = 1;
      else void'(slave_q.pop_front());
    end
    if (acc) begin
      slave_q.push_back('{ga, cyc + int'($urandom_range(lat_max, lat_min))});
      if (g == 1) begin exp_data.push_back(rd_of(ga)); data_acc = 1; end
      else begin exp_inst.push_back(rd_of(ga)); inst_acc = 1; end
    end
    held = req_exp && !mem_addr_ok;
    held_owner = g;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (!inst_sram_req || inst_acc) begin
      inst_sram_req = 0;
      if (inst_left > 0 && $urandom_range(99) < issue_pct) begin
        inst_sram_req = 1;
        inst_sram_addr = 32'hbfc0_0000 + (32'(inst_n) << 2);
        inst_sram_size = 2'd2;
        inst_n++;
        inst_left--;
      end
    end
    if (!data_sram_req || data_acc) begin
      data_sram_req = 0;
      if (data_left > 0 && $urandom_range(99) < issue_pct) begin
        data_sram_req = 1;
        data_sram_addr = 32'h8000_1000 + (32'(data_n) << 2);
        data_sram_wr = 1'($urandom_range(1));
        data_sram_size = 2'd2;
        data_sram_wstrb = 4'($urandom);
        data_sram_wdata = $urandom;
        data_n++;
        data_left--;
      end
    end
    mem_data_ok = force_dok || (slave_q.size() > 0 && slave_q[0].due <= cyc);
    spur = mem_data_ok && slave_q.size() == 0;
    mem_rdata = slave_q.size() > 0 ? rd_of(slave_q[0].addr) : $urandom;
    mem_addr_ok = !force_stall && $urandom_range(99) < ok_pct;
    #1;
    eval();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((slave_q.size() > 0 || inst_sram_req || data_sram_req || inst_left > 0 || data_left > 0) && n < limit) begin
      step();
      n++;
    end
    #2;
    checks++;
    if (n < limit) passes++;
    else $display("FAIL drain: timeout after %0d cycles with %0d outstanding", n, slave_q.size());
    chk("inst_scoreboard_empty", exp_inst.size(), 0);
    chk("data_scoreboard_empty", exp_data.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    inst_sram_req = 0;
    data_sram_req = 0;
    mem_addr_ok = 0;
    mem_data_ok = 0;
    mem_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    slave_q.delete(); exp_inst.delete(); exp_data.delete();
    held = 0; perr_exp = 0; spur = 0; inst_acc = 0; data_acc = 0;
    inst_left = 0; data_left = 0; inst_n = 0; data_n = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, 0);
    chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rst_protocol_err", protocol_err, 0);
  endtask

  // Monitor: every master response must pop that master's own scoreboard queue.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("data_ok_count", 32'(inst_sram_data_ok) + 32'(data_sram_data_ok), mem_data_ok && !spur);
      if (inst_sram_data_ok) begin
        if (exp_inst.size() == 0) begin checks++; $display("FAIL inst_route: unexpected inst data_ok, rdata %h", inst_sram_rdata); end
        else chk("inst_rdata", inst_sram_rdata, exp_inst.pop_front());
      end
      if (data_sram_data_ok) begin
        if (exp_data.size() == 0) begin checks++; $display("FAIL data_route: unexpected data data_ok, rdata %h", data_sram_rdata); end
        else chk("data_rdata", data_sram_rdata, exp_data.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    lat_min = 2; lat_max = 2; inst_left = 1;
    drain(50);
    lat_min = 1; lat_max = 3; inst_left = 1; data_left = 1;
    drain(50);
    force_stall = 1; inst_left = 1;
    step();
    data_left = 1;
    step(); step();
    force_stall = 0;
    drain(50);
    lat_min = 1000; lat_max = 1000; inst_left = 5;
    repeat (6) step();
    chk("full_blocked", mem_req, 0);
    lat_min = 1; lat_max = 1;
    slave_q[0].due = cyc + 1;
    step();
    step();
    foreach (slave_q[i]) slave_q[i].due = cyc + 1;
    drain(50);
    lat_min = 1; lat_max = 3; issue_pct = 60; ok_pct = 70; inst_left = 5; data_left = 5;
    drain(300);
    lat_min = 1; lat_max = 6; issue_pct = 80; ok_pct = 60; inst_left = 60; data_left = 60;
    drain(3000);
    force_dok = 1;
    step();
    force_dok = 0;
    step(); step();
    chk("perr_sticky", protocol_err, 1);
    do_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
